// File: rtl/pad_motion_controller.sv
// rtl/pad_motion_controller.sv - pad top-Y motion controller with speed ramp, manual/AI command and border saturation
module pad_motion_controller #(
    parameter int         Y_W         = 10,
    parameter int         SCREEN_H    = 768,
    parameter int         TOP_BORDER  = 16,
    parameter int         PAD_H       = 144,
    parameter int         Y_INIT      = 312,
    parameter int         V_MIN       = 1,
    parameter int         V_MAX       = 8,
    parameter int         ACCEL_TICKS = 4,
    parameter int         AI_DEADBAND = 4,
    parameter logic [1:0] PLAY_CODE   = 2'b01
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         timing_tick,
    input  logic                         up_in,
    input  logic                         down_in,
    input  logic                         mode_ai,
    input  logic [Y_W-1:0]               ball_y,
    input  logic [1:0]                   state,
    output logic [Y_W-1:0]               y_pad,
    output logic [$clog2(V_MAX+1)-1:0]   speed,
    output logic                         dir_up,
    output logic                         dir_down,
    output logic                         at_top,
    output logic                         at_bottom
);

    localparam int SPD_W = $clog2(V_MAX + 1);
    localparam int CNT_W = $clog2(ACCEL_TICKS + 1);

    localparam logic [Y_W:0]       L_TOP  = (Y_W+1)'(TOP_BORDER);
    localparam logic [Y_W:0]       L_BOT  = (Y_W+1)'(SCREEN_H - PAD_H);
    localparam logic [Y_W:0]       L_HALF = (Y_W+1)'(PAD_H / 2);
    localparam logic [Y_W:0]       L_DB   = (Y_W+1)'(AI_DEADBAND);
    localparam logic [Y_W:0]       L_INIT = (Y_W+1)'(Y_INIT);
    localparam logic [SPD_W-1:0]   L_VMIN = SPD_W'(V_MIN);
    localparam logic [SPD_W-1:0]   L_VMAX = SPD_W'(V_MAX);
    localparam logic [CNT_W-1:0]   L_ACC  = CNT_W'(ACCEL_TICKS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STILL = 2'd1,
        S_UP    = 2'd2,
        S_DOWN  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    state_t             w_want;
    logic [Y_W:0]       r_y;
    logic [Y_W:0]       w_y_nx;
    logic [SPD_W-1:0]   r_speed;
    logic [SPD_W-1:0]   w_speed_nx;
    logic [SPD_W-1:0]   w_speed_inc;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               r_up_s1;
    logic               r_up_s2;
    logic               r_dn_s1;
    logic               r_dn_s2;
    logic [Y_W-1:0]     r_ball;

    logic               w_play;
    logic               w_move;
    logic [Y_W:0]       w_center;
    logic [Y_W:0]       w_lo;
    logic [Y_W:0]       w_hi;
    logic [Y_W:0]       w_ball_ext;
    logic               w_ai_up;
    logic               w_ai_down;
    logic [Y_W:0]       w_spd_ext;
    logic [Y_W:0]       w_up_lim;
    logic [Y_W:0]       w_diff;
    logic [Y_W:0]       w_sum;

    // Buttons are asynchronous; the ball coordinate only needs one stage of alignment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_up_s1 <= 1'b0;
            r_up_s2 <= 1'b0;
            r_dn_s1 <= 1'b0;
            r_dn_s2 <= 1'b0;
            r_ball  <= '0;
        end else begin
            r_up_s1 <= up_in;
            r_up_s2 <= r_up_s1;
            r_dn_s1 <= down_in;
            r_dn_s2 <= r_dn_s1;
            r_ball  <= ball_y;
        end
    end

    // Lower dead-zone edge clamps at 0 so a pad near the top never wraps the compare.
    assign w_center   = r_y + L_HALF;
    assign w_lo       = (w_center >= L_DB) ? (w_center - L_DB) : '0;
    assign w_hi       = w_center + L_DB;
    assign w_ball_ext = {1'b0, r_ball};
    assign w_ai_up    = (w_ball_ext < w_lo);
    assign w_ai_down  = (w_ball_ext > w_hi);

    always_comb begin
        w_want = S_STILL;
        if (mode_ai) begin
            if (w_ai_up)
                w_want = S_UP;
            else if (w_ai_down)
                w_want = S_DOWN;
        end else begin
            if (r_up_s2 && !r_dn_s2)
                w_want = S_UP;
            else if (r_dn_s2 && !r_up_s2)
                w_want = S_DOWN;
        end
    end

    assign w_play      = (state == PLAY_CODE);
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_speed_inc = (r_speed >= L_VMAX) ? L_VMAX : (r_speed + 1'b1);

    always_comb begin
        w_state_nx = r_state;
        w_speed_nx = r_speed;
        w_cnt_nx   = r_cnt;
        w_move     = 1'b0;
        if (!w_play) begin
            w_state_nx = S_IDLE;
            w_speed_nx = '0;
            w_cnt_nx   = '0;
        end else if (r_state == S_IDLE) begin
            w_state_nx = S_STILL;
        end else if (timing_tick) begin
            if (w_want == S_STILL) begin
                w_state_nx = S_STILL;
                w_speed_nx = '0;
                w_cnt_nx   = '0;
            end else if (w_want != r_state) begin
                w_state_nx = w_want;
                w_speed_nx = L_VMIN;
                w_cnt_nx   = '0;
                w_move     = 1'b1;
            end else begin
                w_move = 1'b1;
                if (w_cnt_inc == L_ACC) begin
                    w_cnt_nx   = '0;
                    w_speed_nx = w_speed_inc;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
        end
    end

    // The move uses the speed just computed for this tick, saturating exactly at each border.
    assign w_spd_ext = {{(Y_W + 1 - SPD_W){1'b0}}, w_speed_nx};
    assign w_up_lim  = L_TOP + w_spd_ext;
    assign w_diff    = r_y - w_spd_ext;
    assign w_sum     = r_y + w_spd_ext;

    always_comb begin
        w_y_nx = r_y;
        if (!w_play) begin
            w_y_nx = L_INIT;
        end else if (w_move && (w_state_nx == S_UP)) begin
            w_y_nx = (r_y < w_up_lim) ? L_TOP : w_diff;
        end else if (w_move && (w_state_nx == S_DOWN)) begin
            w_y_nx = (w_sum > L_BOT) ? L_BOT : w_sum;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_y     <= L_INIT;
            r_speed <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_y     <= w_y_nx;
            r_speed <= w_speed_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    assign y_pad     = r_y[Y_W-1:0];
    assign speed     = r_speed;
    assign dir_up    = (r_state == S_UP);
    assign dir_down  = (r_state == S_DOWN);
    assign at_top    = (r_state != S_IDLE) && (r_y == L_TOP);
    assign at_bottom = (r_state != S_IDLE) && (r_y == L_BOT);

endmodule

// File: tb/tb_pad_motion_controller.sv
// tb/tb_pad_motion_controller.sv - directed and randomized checks of pad_motion_controller against a behavioural model
module tb_pad_motion_controller;

    localparam logic [1:0] PLAY = 2'b01;

    logic       clk = 1'b0;
    logic       rst;
    logic       timing_tick;
    logic       up_in;
    logic       down_in;
    logic       mode_ai;
    logic [9:0] ball_y;
    logic [1:0] state;
    logic [9:0] y_pad;
    logic [3:0] speed;
    logic       dir_up;
    logic       dir_down;
    logic       at_top;
    logic       at_bottom;

    int total = 0;
    int bad   = 0;

    // Model: fsm 0=idle 1=still 2=up 3=down; sync history kept as plain bits.
    int m_y, m_spd, m_cnt, m_fsm, m_ball;
    bit m_u1, m_u2, m_d1, m_d2;

    pad_motion_controller dut (
        .clk         (clk),
        .rst         (rst),
        .timing_tick (timing_tick),
        .up_in       (up_in),
        .down_in     (down_in),
        .mode_ai     (mode_ai),
        .ball_y      (ball_y),
        .state       (state),
        .y_pad       (y_pad),
        .speed       (speed),
        .dir_up      (dir_up),
        .dir_down    (dir_down),
        .at_top      (at_top),
        .at_bottom   (at_bottom)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_y = 312; m_spd = 0; m_cnt = 0; m_fsm = 0; m_ball = 0;
        m_u1 = 0; m_u2 = 0; m_d1 = 0; m_d2 = 0;
    endtask

    task automatic model_edge();
        int want;
        int c;
        if (!rst) begin
            model_reset();
            return;
        end
        want = 1;
        if (mode_ai) begin
            c = m_y + 72;
            if (m_ball < c - 4)      want = 2;
            else if (m_ball > c + 4) want = 3;
        end else begin
            if (m_u2 && !m_d2)       want = 2;
            else if (m_d2 && !m_u2)  want = 3;
        end
        if (state != PLAY) begin
            m_fsm = 0; m_y = 312; m_spd = 0; m_cnt = 0;
        end else if (m_fsm == 0) begin
            m_fsm = 1;
        end else if (timing_tick) begin
            if (want == 1) begin
                m_fsm = 1; m_spd = 0; m_cnt = 0;
            end else begin
                if (want != m_fsm) begin
                    m_fsm = want; m_spd = 1; m_cnt = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == 4) begin
                        m_cnt = 0;
                        m_spd = (m_spd + 1 > 8) ? 8 : m_spd + 1;
                    end
                end
                if (m_fsm == 2) m_y = (m_y - m_spd < 16) ? 16 : m_y - m_spd;
                else            m_y = (m_y + m_spd > 624) ? 624 : m_y + m_spd;
            end
        end
        m_u2 = m_u1; m_u1 = up_in;
        m_d2 = m_d1; m_d1 = down_in;
        m_ball = ball_y;
    endtask

    task automatic check_all();
        chk("y_pad", y_pad, m_y);
        chk("speed", speed, m_spd);
        chk("dir_up", dir_up, (m_fsm == 2));
        chk("dir_down", dir_down, (m_fsm == 3));
        chk("at_top", at_top, (m_fsm != 0 && m_y == 16));
        chk("at_bottom", at_bottom, (m_fsm != 0 && m_y == 624));
    endtask

    task automatic cyc(input bit tick);
        timing_tick = tick;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        timing_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cyc(1'b0);
            cyc(1'b0);
            cyc(1'b1);
        end
    endtask

    initial begin
        rst = 1'b1; timing_tick = 0; up_in = 0; down_in = 0; mode_ai = 0;
        ball_y = '0; state = 2'b00;
        #2 rst = 1'b0;
        #1;
        chk("reset_y", y_pad, 312);
        chk("reset_speed", speed, 0);
        chk("reset_flags", {dir_up, dir_down, at_top, at_bottom}, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        state = PLAY;
        cyc(1'b0);

        ticks(10);
        chk("still_y", y_pad, 312);
        chk("still_speed", speed, 0);

        down_in = 1;
        ticks(8);
        chk("down8_y", y_pad, 324);
        chk("down8_speed", speed, 2);

        down_in = 0; up_in = 1;
        ticks(200);
        chk("top_y", y_pad, 16);
        chk("top_flag", at_top, 1);

        up_in = 0; down_in = 1;
        ticks(200);
        chk("bot_y", y_pad, 624);
        chk("bot_flag", at_bottom, 1);

        up_in = 1; down_in = 0;
        ticks(1);
        chk("rev_speed", speed, 1);
        chk("rev_dir_up", dir_up, 1);
        down_in = 1;
        ticks(1);
        chk("both_speed", speed, 0);
        chk("both_dirs", {dir_up, dir_down}, 0);

        state = 2'b00;
        cyc(1'b0);
        chk("idle_y", y_pad, 312);
        state = PLAY; up_in = 0; down_in = 0;
        cyc(1'b0);
        mode_ai = 1; ball_y = 10'd100;
        ticks(1);
        chk("ai_up", dir_up, 1);
        ball_y = 10'd386;
        ticks(1);
        chk("ai_dead_dirs", {dir_up, dir_down}, 0);
        chk("ai_dead_speed", speed, 0);
        ball_y = 10'd500;
        ticks(1);
        chk("ai_down", dir_down, 1);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                up_in   = $urandom_range(0, 1);
                down_in = $urandom_range(0, 1);
            end
            if ($urandom_range(0, 63) == 0) mode_ai = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 0)
                ball_y = 10'((m_y + 72 + $urandom_range(0, 40)) - 20);
            else if ($urandom_range(0, 15) == 0)
                ball_y = 10'($urandom_range(0, 767));
            if ($urandom_range(0, 199) == 0) state = 2'($urandom_range(0, 3));
            else if (state != PLAY && $urandom_range(0, 3) == 0) state = PLAY;
            cyc($urandom_range(0, 3) == 0);
        end

        state = PLAY; mode_ai = 0; up_in = 0; down_in = 1;
        cyc(1'b0);
        ticks(3);
        state = 2'b10;
        cyc(1'b0);
        chk("leave_y", y_pad, 312);
        chk("leave_speed", speed, 0);
        chk("leave_dir", dir_down, 0);

        state = PLAY;
        cyc(1'b0);
        ticks(6);
        chk("premove_y_moved", (y_pad != 312), 1);
        timing_tick = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst_y", y_pad, 312);
        chk("arst_speed", speed, 0);
        chk("arst_dirs", {dir_up, dir_down, at_top, at_bottom}, 0);
        model_reset();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        timing_tick = 1'b0;
        rst = 1'b1;
        cyc(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
